// File: rtl/pc_fetch_unit.sv
// Fetch-address generator: issues sequential fetch requests and redirects on
// taken branches and jumps resolved in EX, holding targets across stalled handshakes.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [1:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        br_f,
  input  logic [31:0] alu_c,
  input  logic        stall,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        flush,
  output logic        wrong_path,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT    = 2'b00,
    REQ     = 2'b01,
    STALLED = 2'b10
  } state_e;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        redirect;
  logic        handshake;
  logic [31:0] target;
  logic [31:0] rel_target;

  assign rel_target = ex_pc + ex_imm;

  always_comb begin
    redirect = 1'b0;
    target   = rel_target;
    unique case (npc_op)
      NPC_SEQ:  redirect = 1'b0;
      NPC_BR:   redirect = ex_valid & br_f;
      NPC_JAL:  redirect = ex_valid;
      NPC_JALR: begin
        redirect = ex_valid;
        target   = alu_c & 32'hFFFF_FFFE;
      end
      default:  redirect = 1'b0;
    endcase
  end

  assign handshake = if_req & if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = stall ? STALLED : REQ;
      REQ:     if (handshake) state_d = stall ? STALLED : REQ;
      STALLED: if (!stall) state_d = REQ;
      default: state_d = BOOT;
    endcase
  end

  // Status pulses are qualified by rst_n so they drop asynchronously with reset.
  always_comb begin
    if_req     = (state_q == REQ);
    flush      = rst_n & redirect;
    misalign   = rst_n & redirect & target[1];
    wrong_path = rst_n & if_req & if_ready & (pend_v_q | redirect);
  end

  // In REQ the address is frozen until accepted, so redirects are parked in the
  // pending register; outside REQ nothing is outstanding and targets load directly.
  always_comb begin
    if_addr_d  = if_addr_q;
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    if (state_q == REQ) begin
      if (handshake) begin
        pc_d     = if_addr_q;
        pend_v_d = 1'b0;
        if (redirect) begin
          if_addr_d = target;
        end else if (pend_v_q) begin
          if_addr_d = pend_tgt_q;
        end else begin
          if_addr_d = if_addr_q + 32'd4;
        end
      end else if (redirect) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = target;
      end
    end else begin
      pend_v_d = 1'b0;
      if (redirect) begin
        if_addr_d = target;
      end else if (pend_v_q) begin
        if_addr_d = pend_tgt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_addr_q  <= RESET_PC;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= RESET_PC;
    end else begin
      if_addr_q  <= if_addr_d;
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign if_addr = if_addr_q;
  assign pc      = pc_q;
  assign pc4     = pc_q + 32'd4;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ex_valid  input  1  EX-stage control-flow fields valid this cycle.
REQ-005 SHALL have port npc_op  input  2  00 sequential, 01 conditional branch, 10 JAL, 11 JALR.
REQ-006 SHALL have port ex_pc  input  32  PC of the EX-stage instruction.
REQ-007 SHALL have port ex_imm  input  32  sign-extended immediate of the EX-stage instruction.
REQ-008 SHALL have port br_f  input  1  ALU compare flag; 1 = branch condition true.
REQ-009 SHALL have port alu_c  input  32  ALU result; rs1+imm for JALR.
REQ-010 SHALL have port stall  input  1  hazard stall; blocks issue of new fetch requests.
REQ-011 SHALL have port if_req  output  1  fetch request valid.
REQ-012 SHALL have port if_addr  output  32  fetch address.
REQ-013 SHALL have port if_ready  input  1  instruction memory accepts the request.
REQ-014 SHALL have port pc  output  32  address of the most recently accepted fetch.
REQ-015 SHALL have port pc4  output  32  pc+4, combinational, modulo 2^32.
REQ-016 SHALL have port flush  output  1  one-cycle pulse when a redirect is detected.
REQ-017 SHALL have port wrong_path  output  1  high on a handshake whose address predates a pending redirect.
REQ-018 SHALL have port misalign  output  1  one-cycle pulse when a redirect target has bit 1 set.

Function
REQ-019 SHALL detect a redirect when ex_valid=1 and one of: npc_op=10, npc_op=11, or npc_op=01 with br_f=1; npc_op=00, or npc_op=01 with br_f=0, SHALL NOT redirect.
REQ-020 SHALL compute the target: ex_pc+ex_imm for npc_op 01/10; {alu_c[31:1],1'b0} for 11; all additions 32-bit, wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-021 SHALL pulse flush, and misalign when target[1]=1, combinationally in the detection cycle only; the target is still used unmodified.
REQ-022 SHALL implement states BOOT, REQ, STALLED; if_req=1 only in REQ.
REQ-023 BOOT: the single cycle after reset release; next state is STALLED if stall=1, otherwise REQ.
REQ-024 REQ: if_addr SHALL stay stable until if_req&if_ready; no handshake means remain in REQ.
REQ-025 On handshake: pc<=if_addr; if_addr<=current redirect target, else pending target, else if_addr+4; pending cleared; next state STALLED if stall=1, otherwise REQ.
REQ-026 Redirect in REQ without handshake: latch target into pending register (pend_v=1); if_addr unchanged; a newer redirect overwrites the pending one.
REQ-027 wrong_path SHALL equal if_req&if_ready&(pend_v | redirect this cycle).
REQ-028 STALLED and BOOT: a redirect SHALL load if_addr directly at the next edge; a pending target SHALL be applied to if_addr on entry; STALLED exits to REQ when stall=0.
REQ-029 Redirect-to-visible latency SHALL be 1 cycle in STALLED, and 1 cycle after the handshake in REQ.

Reset
REQ-030 While rst_n=0, independent of clk: if_req=0, if_addr=RESET_PC, pc=RESET_PC, pend_v=0, state=BOOT; flush/misalign/wrong_path SHALL be forced 0.
REQ-031 Reset asserted mid-request SHALL drop if_req immediately and discard any pending target.

Verification
REQ-032 Release reset, if_ready=1, stall=0 -> if_req rises 1 cycle after release; if_addr 0,4,8,... on successive cycles; pc lags by one handshake.
REQ-033 if_ready=0 for 3 cycles, JAL ex_pc=0x100 ex_imm=0x40 in cycle 1 -> flush pulses; if_addr holds; on the handshake wrong_path=1 and next if_addr=0x140.
REQ-034 Branch npc_op=01 br_f=0, then br_f=1, ex_pc=0x20 ex_imm=-8 -> first: no flush, sequential; second: flush, target 0x18.
REQ-035 JALR alu_c=0x203 -> target 0x202, misalign pulses, flush pulses.
REQ-036 stall=1 while in STALLED, JAL target 0x80 -> if_req stays 0, if_addr=0x80 next cycle; stall=0 -> request 0x80 issued.
REQ-037 Pending redirect outstanding, rst_n pulsed low -> if_req=0 at once; after release, fetch resumes at RESET_PC.
